// File: rtl/laser_blob_tracker.sv
// Laser-spot tracker: classifies pixels by colour dominance and keeps the longest qualifying
// horizontal run per frame. Define LASER_BLOB_DEBUG_EN to add the debug/hit_count outputs.
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

module laser_blob_tracker #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 16,
  parameter int MIN_RUN = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   sof,
  input  logic                   eol,
  input  logic [1:0]             channel_sel,
  input  logic [7:0]             threshold,
  input  logic [COORD_W-1:0]     pixel_col,
  input  logic [COORD_W-1:0]     pixel_row,
  input  logic [`PIXEL_SIZE-1:0] data,
  output logic [2*COORD_W-1:0]   laser_xy,
  output logic                   laser_valid,
  output logic                   frame_pulse,
  output logic [CNT_W-1:0]       run_len
`ifdef LASER_BLOB_DEBUG_EN
  ,
  output logic [`PIXEL_SIZE-1:0] debug,
  output logic [31:0]            hit_count
`endif
);

  localparam logic [CNT_W-1:0] MIN_L   = CNT_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  // ---------------- classification ----------------
  logic [7:0] r_ch, g_ch, b_ch, tgt, oth, dom;
  logic       hit;

  assign g_ch = data[7:0];
  assign b_ch = data[15:8];
  assign r_ch = data[23:16];

  always_comb begin
    tgt = r_ch;
    oth = (g_ch > b_ch) ? g_ch : b_ch;
    case (channel_sel)
      2'd1: begin
        tgt = g_ch;
        oth = (r_ch > b_ch) ? r_ch : b_ch;
      end
      2'd2: begin
        tgt = b_ch;
        oth = (r_ch > g_ch) ? r_ch : g_ch;
      end
      default: begin
      end
    endcase
    dom = (tgt > oth) ? tgt - oth : 8'd0;
  end

  assign hit = dom > threshold;

  // ---------------- run tracking state ----------------
  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q, best_len_q;
  logic [COORD_W-1:0]   start_col_q, run_row_q, best_x_q, best_y_q;
  logic                 found_q;
  logic [2*COORD_W-1:0] laser_xy_q;
  logic                 laser_valid_q, frame_pulse_q;
  logic [CNT_W-1:0]     run_len_q;

  // sof discards any open run and the frame best before this pixel is looked at
  logic               eol_eff, in_run, run_end, better;
  logic [CNT_W-1:0]   best_base, len_d, end_len;
  logic [COORD_W-1:0] start_d, row_d, ctr_x;

  always_comb begin
    eol_eff   = eol && !sof;
    in_run    = (state_q != IDLE) && !sof;
    best_base = sof ? '0 : best_len_q;
    len_d     = in_run ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE) : ONE;
    start_d   = in_run ? start_col_q : pixel_col;
    row_d     = in_run ? run_row_q : pixel_row;
    end_len   = hit ? len_d : cnt_q;
    run_end   = in_run ? (!hit || eol_eff) : (hit && eol_eff);
    better    = run_end && (end_len >= MIN_L) && (end_len > best_base);
    ctr_x     = start_d + COORD_W'((end_len - ONE) >> 1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      start_col_q   <= '0;
      run_row_q     <= '0;
      best_len_q    <= '0;
      best_x_q      <= '0;
      best_y_q      <= '0;
      found_q       <= 1'b0;
      laser_xy_q    <= '0;
      laser_valid_q <= 1'b0;
      frame_pulse_q <= 1'b0;
      run_len_q     <= '0;
    end else begin
      frame_pulse_q <= 1'b0;
      if (en) begin
        if (sof) begin
          frame_pulse_q <= 1'b1;
          laser_valid_q <= found_q;
          run_len_q     <= found_q ? best_len_q : '0;
          if (found_q) laser_xy_q <= {best_x_q, best_y_q};
          best_len_q    <= '0;
          found_q       <= 1'b0;
        end
        if (better) begin
          best_len_q <= end_len;
          best_x_q   <= ctr_x;
          best_y_q   <= row_d;
          found_q    <= 1'b1;
        end
        if (run_end) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (hit) begin
          cnt_q       <= len_d;
          start_col_q <= start_d;
          run_row_q   <= row_d;
          state_q     <= (len_d >= MIN_L) ? LONG : SHORT;
        end else if (sof) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      end
    end
  end

  assign laser_xy    = laser_xy_q;
  assign laser_valid = laser_valid_q;
  assign frame_pulse = frame_pulse_q;
  assign run_len     = run_len_q;

`ifdef LASER_BLOB_DEBUG_EN
  logic [31:0] hit_acc_q, hit_count_q;

  assign debug     = hit ? {dom, {(`PIXEL_SIZE-8){1'b0}}} : '0;
  assign hit_count = hit_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_acc_q   <= '0;
      hit_count_q <= '0;
    end else if (en) begin
      if (sof) begin
        hit_count_q <= hit_acc_q;
        hit_acc_q   <= {31'd0, hit};
      end else if (hit) begin
        hit_acc_q <= hit_acc_q + 32'd1;
      end
    end
  end
`endif

endmodule
